// File: rtl/hiscore_ram_bridge.sv
// hiscore_ram_bridge
//   Game-side responder for the hiscore save/restore bus. It sits in front of
//   the single-port CPU work RAM. When the hiscore engine asks for the RAM, the
//   bridge stalls the CPU, waits for the CPU to finish its current bus cycle,
//   lets the bus settle for GUARD cycles, and then gives the RAM port to the
//   hiscore engine. When hs_access drops, the bridge spends one RELEASE cycle
//   with the mux back on the CPU, then returns to IDLE and releases the stall.
//
// Ports
//   clk_sys, reset_n      system clock; synchronous active-low reset
//   hs_access             hiscore engine requests the RAM
//   hs_address/_data_in   hiscore address and write data
//   hs_write              hiscore write strobe, one byte per cycle
//   hs_data_out           hiscore read data, registered, 2-cycle latency
//   hs_grant              RAM currently owned by the hiscore side
//   cpu_ce                CPU clock-enable; a pulse ends a CPU bus cycle
//   cpu_sel/addr/dout/we  CPU access to this RAM
//   cpu_din               RAM read data to the CPU (combinational)
//   cpu_hold              stall request to the CPU clock-enable generator
//   ram_addr/din/we       RAM port
//   ram_dout              RAM read data, 1-cycle synchronous read
module hiscore_ram_bridge #(
  parameter logic [15:0] RAM_BASE = 16'hE000,
  parameter int          AW       = 11,
  parameter int          GUARD    = 2
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          hs_access,
  input  logic [15:0]   hs_address,
  input  logic [7:0]    hs_data_in,
  input  logic          hs_write,
  output logic [7:0]    hs_data_out,
  output logic          hs_grant,
  input  logic          cpu_ce,
  input  logic          cpu_sel,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  input  logic          cpu_we,
  output logic [7:0]    cpu_din,
  output logic          cpu_hold,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HOLD    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_GRANT   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [3:0] GUARD_C = 4'(GUARD);

  logic [2:0] state;
  logic [3:0] guard_cnt;
  logic       in_grant;
  logic       in_win;
  logic       rd_issue;
  logic       rd_vld_q;
  logic       rd_win_q;

  assign in_grant = (state == S_GRANT);
  assign hs_grant = in_grant;
  // The stall stays up from HOLD through RELEASE; it drops only once the
  // bridge is back in IDLE and the mux is already on the CPU.
  assign cpu_hold = (state != S_IDLE);
  assign in_win   = (hs_address[15:AW] == RAM_BASE[15:AW]);
  assign cpu_din  = ram_dout;

  // Ownership FSM
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      guard_cnt <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs_access) state <= S_HOLD;
        end
        S_HOLD: begin
          // cpu_hold is already high here, so any cpu_ce pulse seen in this
          // state closes the CPU's last bus cycle.
          if (!hs_access) begin
            state <= S_RELEASE;
          end else if (cpu_ce) begin
            if (GUARD_C == 4'd0) begin
              state <= S_GRANT;
            end else begin
              guard_cnt <= GUARD_C;
              state     <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (!hs_access) begin
            state <= S_RELEASE;
          end else begin
            guard_cnt <= guard_cnt - 4'd1;
            if (guard_cnt == 4'd1) state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!hs_access) state <= S_RELEASE;
        end
        S_RELEASE: begin
          // Always passes through IDLE, even when hs_access is already back.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM port mux. The write enable is gated by reset so that a write in
  // flight when reset hits is abandoned in the same cycle.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_dout;
    ram_we   = cpu_sel & cpu_we & cpu_ce & ~cpu_hold;
    if (in_grant) begin
      ram_addr = hs_address[AW-1:0];
      ram_din  = hs_data_in;
      ram_we   = hs_write & in_win;
    end
    if (!reset_n) ram_we = 1'b0;
  end

  // Hiscore read path. A read is any granted non-write cycle; the window
  // flag travels with it so that out-of-window reads return 00 instead of the
  // aliased RAM byte. The output only changes when a read completes.
  assign rd_issue = in_grant & ~hs_write;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rd_vld_q    <= 1'b0;
      rd_win_q    <= 1'b0;
      hs_data_out <= 8'h00;
    end else begin
      rd_vld_q <= rd_issue;
      rd_win_q <= in_win;
      if (rd_vld_q) hs_data_out <= rd_win_q ? ram_dout : 8'h00;
    end
  end

endmodule
